// File: rtl/bit_serializer_if.sv
// Handshake bundle for the parallel-in / serial-out transmitter: word side and bit side.
interface bit_serializer_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_rev;
   logic             ser_valid;
   logic             ser_ready;
   logic             ser_out;
   logic             ser_last;
   logic             busy;

   modport master (
      output in_valid, in_data, in_rev, ser_ready,
      input  in_ready, ser_valid, ser_out, ser_last, busy
   );

   modport slave (
      input  in_valid, in_data, in_rev, ser_ready,
      output in_ready, ser_valid, ser_out, ser_last, busy
   );
endinterface

// File: rtl/bit_serializer.sv
// Serial-link transmitter: loads a WIDTH-bit word and shifts it out one bit per cycle
// from the top of the shift register, MSB-first or bit-reversed (LSB-first).
module bit_serializer #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   bit_serializer_if.slave  bus
);
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [CNT_W-1:0] r_cnt;

   logic w_shift;
   logic w_last;
   logic w_in_ready;
   logic w_accept;
   logic w_bit_take;

   function automatic logic [WIDTH-1:0] f_reverse(input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = d[WIDTH-1-i];
      end
      return r;
   endfunction

   assign w_shift    = (r_state == S_SHIFT);
   assign w_last     = w_shift && (r_cnt == LAST_CNT);
   assign w_bit_take = w_shift && bus.ser_ready;
   // A new word may enter on the final-bit handshake, so there is no bubble between words.
   assign w_in_ready = rst_n && (!w_shift || (w_last && bus.ser_ready));
   assign w_accept   = bus.in_valid && w_in_ready;

   // Outputs are gated by rst_n so a reset aborts the word in the same cycle.
   assign bus.in_ready  = w_in_ready;
   assign bus.ser_valid = rst_n && w_shift;
   assign bus.ser_out   = rst_n && w_shift && r_shreg[WIDTH-1];
   assign bus.ser_last  = rst_n && w_last;
   assign bus.busy      = rst_n && w_shift;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_state <= S_SHIFT;
         r_shreg <= bus.in_rev ? f_reverse(bus.in_data) : bus.in_data;
         r_cnt   <= '0;
      end else if (w_bit_take) begin
         if (w_last) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
         end else begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_bit_serializer.sv
// Directed and random stimulus for bit_serializer, checked against a bit-queue reference model.
module tb_bit_serializer;
   logic clk;
   logic rst_n;

   bit_serializer_if #(.WIDTH(16)) bus();

   bit_serializer #(.WIDTH(16), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int nassert = 0;
   int nfail   = 0;
   bit mq[$];
   logic [31:0] coll;
   int nhs;
   int nvalid;
   int last_at;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nassert++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clr();
      coll    = '0;
      nhs     = 0;
      nvalid  = 0;
      last_at = 0;
   endtask

   // One clock cycle: drive, compare at the falling edge, advance the model, step to posedge+1.
   task automatic step(input logic v, input logic [15:0] d, input logic rev,
                       input logic sr, input logic rn);
      logic e_valid, e_out, e_last, e_ready;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_rev    = rev;
      bus.ser_ready = sr;
      rst_n         = rn;
      #4;
      e_valid = rn && (mq.size() > 0);
      e_out   = e_valid ? mq[0] : 1'b0;
      e_last  = e_valid && (mq.size() == 1);
      e_ready = rn && ((mq.size() == 0) || ((mq.size() == 1) && sr));
      check("ser_valid", {31'd0, bus.ser_valid}, {31'd0, e_valid});
      check("ser_out",   {31'd0, bus.ser_out},   {31'd0, e_out});
      check("ser_last",  {31'd0, bus.ser_last},  {31'd0, e_last});
      check("in_ready",  {31'd0, bus.in_ready},  {31'd0, e_ready});
      check("busy",      {31'd0, bus.busy},      {31'd0, e_valid});
      if (rn && bus.ser_valid) nvalid++;
      if (rn && bus.ser_valid && sr) begin
         coll = {coll[30:0], bus.ser_out};
         nhs++;
         if (bus.ser_last) last_at = nhs;
      end
      if (!rn) begin
         mq.delete();
      end else begin
         if (e_valid && sr) void'(mq.pop_front());
         if (v && e_ready) begin
            for (int i = 0; i < 16; i++) mq.push_back(rev ? d[i] : d[15-i]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_rev    = 1'b0;
      bus.ser_ready = 1'b0;
      rst_n         = 1'b0;
      @(posedge clk);
      #1;

      // Reset held, then idle.
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);

      // 0x1234 MSB-first.
      clr();
      step(1'b1, 16'h1234, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
      check("msb_word", coll, 32'h0000_1234);
      check("msb_last_at", last_at, 16);
      step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
      check("msb_idle", {31'd0, bus.busy}, 32'd0);

      // 0x1234 and 0x8001 LSB-first.
      clr();
      step(1'b1, 16'h1234, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
      check("rev_1234", coll[15:0], 32'h2C48);
      clr();
      step(1'b1, 16'h8001, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
      check("rev_8001", coll[15:0], 32'h8001);

      // 0xA5F0 with a 3-cycle stall after bit 5.
      clr();
      step(1'b1, 16'hA5F0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 19; i++) step(1'b0, 16'h0, 1'b0, !(i >= 5 && i < 8), 1'b1);
      check("stall_word", coll[15:0], 32'hA5F0);
      check("stall_bits", nhs, 16);
      check("stall_cycles", nvalid, 19);
      check("stall_last_at", last_at, 16);

      // Back-to-back 0xFFFF then 0x0000 with in_valid held.
      clr();
      step(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
      check("b2b_bits", coll, 32'hFFFF_0000);
      check("b2b_valid_cycles", nvalid, 32);
      step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
      check("b2b_idle", {31'd0, bus.ser_valid}, 32'd0);

      // Reset at bit 7 of 0xBEEF, then 0x0F0F.
      clr();
      step(1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
      check("pre_rst_bits", coll[6:0], 32'h5F);
      step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      check("rst_valid_low", {31'd0, bus.ser_valid}, 32'd0);
      step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
      check("post_rst_valid_low", {31'd0, bus.ser_valid}, 32'd0);
      clr();
      step(1'b1, 16'h0F0F, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
      check("post_rst_word", coll[15:0], 32'h0F0F);
      check("post_rst_bits", nhs, 16);

      // Random traffic, stalls and occasional resets.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom),
              ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end
endmodule
